load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Executes RV32I loads/stores for the core: checks alignment, drives a valid/ready
//   word-addressed memory bus with byte strobes, and returns the extended load value.
//   Sits upstream of the writeback-select multiplexer: resp_rdata feeds its memory-data
//   input (control=2'b01). Multi-cycle; the core stalls on req_ready=0.
// PARAMETERS
//   ADDR_WIDTH  32   byte-address width of req_addr / mem_addr
//   TIMEOUT     255  max ACCESS cycles without mem_ready before fault; 0 = no timeout; <=65535
// PORTS
//   clk         in   1           rising-edge clock
//   rst         in   1           reset, asynchronous, active-high
//   req_valid   in   1           execute stage presents a memory op
//   req_ready   out  1           1 only in IDLE; request accepted when valid & ready
//   req_store   in   1           1 = store, 0 = load
//   req_funct3  in   3           RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr    in   ADDR_WIDTH  byte address (rs1 + imm)
//   req_wdata   in   32          store data (rs2)
//   resp_valid  out  1           one-cycle completion pulse
//   resp_rdata  out  32          extended load data; 0 for stores and faults
//   resp_fault  out  1           misaligned/illegal/timeout; valid with resp_valid
//   mem_valid   out  1           bus request
//   mem_addr    out  ADDR_WIDTH  word-aligned address ({req_addr[AW-1:2],2'b00})
//   mem_wdata   out  32          lane-replicated store data
//   mem_wstrb   out  4           byte enables; 4'b0000 = read
//   mem_ready   in   1           bus completes access this cycle
//   mem_rdata   in   32          read word, valid when mem_ready
// BEHAVIOUR
// - Reset (async): state IDLE; mem_valid, resp_valid, resp_fault = 0; resp_rdata, mem_addr,
//   mem_wdata, mem_wstrb = 0; timeout counter = 0. req_ready = 1 (decoded from IDLE).
// - FSM IDLE -> ACCESS -> RESP -> IDLE, or IDLE -> RESP on fault.
// - IDLE: on req_valid, latch op; legality check:
//   funct3 000/100 any addr; 001/101 need addr[0]=0; 010 needs addr[1:0]=0;
//   011/110/111 illegal; store with funct3[2]=1 illegal.
//   Illegal/misaligned -> RESP, fault=1, no bus activity. Else -> ACCESS.
// - ACCESS: mem_valid=1 with addr/wdata/wstrb stable until mem_ready seen.
//   On mem_ready: register extended rdata (loads), -> RESP, mem_valid=0 next cycle.
//   Timeout: counter counts ACCESS cycles without ready; if TIMEOUT!=0 and count reaches
//   TIMEOUT-1 with mem_ready=0 -> RESP, fault=1 (mem_valid high exactly TIMEOUT cycles).
//   mem_ready on the final timeout cycle wins (normal completion).
// - RESP: resp_valid=1 for one cycle with resp_fault/resp_rdata; -> IDLE. resp_rdata held
//   until the next resp_valid. Back-to-back: new request accepted the cycle after RESP.
// - Latency (accept=cycle 0): zero-wait bus -> mem_valid cycle 1, resp_valid cycle 2;
//   each wait state adds 1; fault -> resp_valid cycle 1.
// - Load extract: byte = mem_rdata >> (8*addr[1:0]); half = mem_rdata >> (16*addr[1]);
//   LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
// - Store: SB wdata={4{wdata[7:0]}}, wstrb=4'b0001<<addr[1:0]; SH wdata={2{wdata[15:0]}},
//   wstrb=4'b0011<<(2*addr[1]); SW wdata unchanged, wstrb=4'b1111.
// - mem_ready outside ACCESS ignored. req_* ignored outside IDLE.
// - Reset mid-ACCESS: mem_valid drops immediately, no resp_valid for the aborted op.
// TESTING
// 1. LW 0x100, ready on first ACCESS cycle, rdata 0xDEADBEEF -> mem_addr 0x100, wstrb 0,
//    resp_valid cycle 2, resp_rdata 0xDEADBEEF, fault 0.
// 2. rdata 0x80112233: LB 0x103 -> 0xFFFFFF80; LBU 0x103 -> 0x00000080;
//    LH 0x102 -> 0xFFFF8011; LHU 0x100 -> 0x00002233.
// 3. SB 0x201 wdata 0x000000A5 -> mem_addr 0x200, wdata 0xA5A5A5A5, wstrb 4'b0010;
//    SH 0x202 wdata 0x1234 -> wdata 0x12341234, wstrb 4'b1100; resp_rdata 0.
// 4. LW 0x102, SH 0x203, funct3 011 -> no mem_valid, resp_valid cycle 1, fault 1.
// 5. TIMEOUT=4, mem_ready low -> mem_valid 4 cycles, then resp fault 1; ready after
//    3 waits -> resp fault 0, correct data.
// 6. rst pulse during ACCESS -> mem_valid 0 asynchronously, req_ready 1 after release,
//    no resp_valid; next LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: alignment check, valid/ready word bus with byte strobes,
// extended load data returned with a one-cycle completion pulse.
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_fault,
    output logic                  mem_valid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ready,
    input  logic [31:0]           mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    localparam logic [15:0] ToLast = 16'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  op_store_q;
    logic [2:0]            op_funct3_q;
    logic [1:0]            op_off_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_wdata_q;
    logic [3:0]            mem_wstrb_q;
    logic [31:0]           rdata_q;
    logic                  fault_q;

    logic                  legal;
    logic [31:0]           st_wdata;
    logic [3:0]            st_wstrb;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [31:0]           ld_data;
    logic                  accept;
    logic                  done_ok;
    logic                  done_to;

    // Alignment / encoding legality of the presented request.
    always_comb begin
        legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b100: legal = 1'b1;
            3'b001, 3'b101: legal = ~req_addr[0];
            3'b010:         legal = (req_addr[1:0] == 2'b00);
            default:        legal = 1'b0;
        endcase
        if (req_store && req_funct3[2]) begin
            legal = 1'b0;
        end
    end

    // Store data is replicated across lanes so the strobe alone selects the bytes.
    always_comb begin
        st_wdata = req_wdata;
        st_wstrb = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin
                st_wdata = {4{req_wdata[7:0]}};
                st_wstrb = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{req_wdata[15:0]}};
                st_wstrb = 4'b0011 << {req_addr[1], 1'b0};
            end
            default: begin
                st_wdata = req_wdata;
                st_wstrb = 4'b1111;
            end
        endcase
        if (!req_store) begin
            st_wstrb = 4'b0000;
        end
    end

    always_comb begin
        ld_byte = mem_rdata[{op_off_q, 3'b000} +: 8];
        ld_half = mem_rdata[{op_off_q[1], 4'b0000} +: 16];
        case (op_funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h000000, ld_byte};
            3'b101:  ld_data = {16'h0000, ld_half};
            default: ld_data = mem_rdata;
        endcase
        if (op_store_q) begin
            ld_data = 32'h0000_0000;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        done_ok = 1'b0;
        done_to = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = 16'h0000;
                    state_d = legal ? StAccess : StResp;
                end
            end
            StAccess: begin
                // A ready arriving on the last allowed cycle still completes normally.
                if (mem_ready) begin
                    done_ok = 1'b1;
                    state_d = StResp;
                end else if ((TIMEOUT != 0) && (cnt_q == ToLast)) begin
                    done_to = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 16'h0001;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 16'h0000;
            op_store_q  <= 1'b0;
            op_funct3_q <= 3'b000;
            op_off_q    <= 2'b00;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0000_0000;
            mem_wstrb_q <= 4'b0000;
            rdata_q     <= 32'h0000_0000;
            fault_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_store_q  <= req_store;
                op_funct3_q <= req_funct3;
                op_off_q    <= req_addr[1:0];
                if (legal) begin
                    mem_addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_wdata_q <= st_wdata;
                    mem_wstrb_q <= st_wstrb;
                end else begin
                    rdata_q <= 32'h0000_0000;
                    fault_q <= 1'b1;
                end
            end
            if (done_ok) begin
                rdata_q <= ld_data;
                fault_q <= 1'b0;
            end else if (done_to) begin
                rdata_q <= 32'h0000_0000;
                fault_q <= 1'b1;
            end
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign mem_valid  = (state_q == StAccess);
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT=4): a cycle-stepped bus responder records
// bus activity and response timing per operation against hand-computed values.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    int          r_mv_first;
    int          r_mv_cnt;
    int          r_resp_t;
    logic        r_ready;
    logic        r_unstable;
    logic        r_fault;
    logic [31:0] r_rdata;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    int          n_resp;

    load_store_unit #(
        .ADDR_WIDTH(32),
        .TIMEOUT   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_store (req_store),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_fault(resp_fault),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request at a negedge; waits < 0 means the bus never answers.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rword, input int waits);
        logic done;
        r_mv_first = -1;
        r_mv_cnt   = 0;
        r_resp_t   = -1;
        r_unstable = 1'b0;
        r_fault    = 1'bx;
        r_rdata    = 32'hxxxx_xxxx;
        r_addr     = 32'hxxxx_xxxx;
        r_wdata    = 32'hxxxx_xxxx;
        r_wstrb    = 4'hx;
        done       = 1'b0;
        @(negedge clk);
        r_ready    = req_ready;
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            mem_ready = 1'b0;
            mem_rdata = 32'h5A5A_5A5A;
            if (mem_valid) begin
                if (r_mv_cnt == 0) begin
                    r_mv_first = cyc;
                    r_addr     = mem_addr;
                    r_wdata    = mem_wdata;
                    r_wstrb    = mem_wstrb;
                end else if (mem_addr !== r_addr || mem_wdata !== r_wdata ||
                             mem_wstrb !== r_wstrb) begin
                    r_unstable = 1'b1;
                end
                if (waits >= 0 && r_mv_cnt == waits) begin
                    mem_ready = 1'b1;
                    mem_rdata = rword;
                end
                r_mv_cnt++;
            end
            if (resp_valid) begin
                r_resp_t = cyc;
                r_rdata  = resp_rdata;
                r_fault  = resp_fault;
                done     = 1'b1;
            end
        end
    endtask

    task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] exp);
        run_op(1'b0, f3, addr, 32'h0, 32'h8011_2233, 0);
        check({tag, " rdata"}, r_rdata, exp);
        check({tag, " fault"}, {31'h0, r_fault}, 32'h0);
    endtask

    task automatic fault_case(input string tag, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr);
        run_op(st, f3, addr, 32'hFFFF_FFFF, 32'h1111_1111, 0);
        check({tag, " mem_valid cycles"}, r_mv_cnt, 0);
        check({tag, " resp cycle"}, r_resp_t, 1);
        check({tag, " fault"}, {31'h0, r_fault}, 32'h1);
        check({tag, " rdata"}, r_rdata, 32'h0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_ready  = 1'b0;
        mem_rdata  = 32'h0;
        repeat (2) @(negedge clk);
        check("reset req_ready", {31'h0, req_ready}, 32'h1);
        check("reset mem_valid", {31'h0, mem_valid}, 32'h0);
        check("reset resp_valid", {31'h0, resp_valid}, 32'h0);
        check("reset resp_rdata", resp_rdata, 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        rst = 1'b0;

        // LW, zero-wait bus
        run_op(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
        check("lw req_ready", {31'h0, r_ready}, 32'h1);
        check("lw mem_valid cycle", r_mv_first, 1);
        check("lw mem_addr", r_addr, 32'h0000_0100);
        check("lw mem_wstrb", {28'h0, r_wstrb}, 32'h0);
        check("lw resp cycle", r_resp_t, 2);
        check("lw rdata", r_rdata, 32'hDEAD_BEEF);
        check("lw fault", {31'h0, r_fault}, 32'h0);
        @(negedge clk);
        check("lw rdata held", resp_rdata, 32'hDEAD_BEEF);
        check("lw resp_valid one cycle", {31'h0, resp_valid}, 32'h0);

        // Extraction and extension from 0x80112233
        load_case("lb 103", 3'b000, 32'h0000_0103, 32'hFFFF_FF80);
        load_case("lbu 103", 3'b100, 32'h0000_0103, 32'h0000_0080);
        load_case("lh 102", 3'b001, 32'h0000_0102, 32'hFFFF_8011);
        load_case("lhu 100", 3'b101, 32'h0000_0100, 32'h0000_2233);
        load_case("lb 101", 3'b000, 32'h0000_0101, 32'h0000_0022);

        // Stores with wait states
        run_op(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 32'hFFFF_FFFF, 2);
        check("sb mem_addr", r_addr, 32'h0000_0200);
        check("sb mem_wdata", r_wdata, 32'hA5A5_A5A5);
        check("sb mem_wstrb", {28'h0, r_wstrb}, 32'h2);
        check("sb mem_valid cycles", r_mv_cnt, 3);
        check("sb stable", {31'h0, r_unstable}, 32'h0);
        check("sb resp cycle", r_resp_t, 4);
        check("sb rdata", r_rdata, 32'h0);
        run_op(1'b1, 3'b001, 32'h0000_0202, 32'h0000_1234, 32'hFFFF_FFFF, 0);
        check("sh mem_wdata", r_wdata, 32'h1234_1234);
        check("sh mem_wstrb", {28'h0, r_wstrb}, 32'hC);
        check("sh rdata", r_rdata, 32'h0);
        run_op(1'b1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1);
        check("sw mem_wdata", r_wdata, 32'hCAFE_F00D);
        check("sw mem_wstrb", {28'h0, r_wstrb}, 32'hF);
        check("sw resp cycle", r_resp_t, 3);

        // Illegal / misaligned
        fault_case("lw 102", 1'b0, 3'b010, 32'h0000_0102);
        fault_case("sh 203", 1'b1, 3'b001, 32'h0000_0203);
        fault_case("f3 011", 1'b0, 3'b011, 32'h0000_0000);
        fault_case("store f3 100", 1'b1, 3'b100, 32'h0000_0000);

        // Timeout and last-cycle ready
        run_op(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h0, -1);
        check("timeout mem_valid cycles", r_mv_cnt, 4);
        check("timeout resp cycle", r_resp_t, 5);
        check("timeout fault", {31'h0, r_fault}, 32'h1);
        check("timeout rdata", r_rdata, 32'h0);
        run_op(1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h1357_9BDF, 3);
        check("late ready resp cycle", r_resp_t, 5);
        check("late ready fault", {31'h0, r_fault}, 32'h0);
        check("late ready rdata", r_rdata, 32'h1357_9BDF);

        // Bus ready while idle is ignored
        @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        check("idle ready mem_valid", {31'h0, mem_valid}, 32'h0);
        check("idle ready resp_valid", {31'h0, resp_valid}, 32'h0);
        mem_ready = 1'b0;

        // Reset during ACCESS
        @(negedge clk);
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0300;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort pre mem_valid", {31'h0, mem_valid}, 32'h1);
        #1 rst = 1'b1;
        #1;
        check("abort mem_valid async", {31'h0, mem_valid}, 32'h0);
        @(negedge clk);
        rst    = 1'b0;
        n_resp = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) n_resp++;
        end
        check("abort no resp", n_resp, 0);
        check("abort req_ready", {31'h0, req_ready}, 32'h1);
        run_op(1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h0BAD_F00D, 0);
        check("after abort resp cycle", r_resp_t, 2);
        check("after abort rdata", r_rdata, 32'h0BAD_F00D);
        check("after abort mem_addr", r_addr, 32'h0000_0300);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
